// File: rtl/keccak_pkg.sv
// Shared Keccak state/beat geometry and the chunk-to-bit mapping.
// The input loader and the output interface both use this mapping.
package keccak_pkg;

    localparam int unsigned STATE_W    = 1600;
    localparam int unsigned BEAT_W     = 200;
    localparam int unsigned NBEATS     = STATE_W / BEAT_W;
    localparam int unsigned BEAT_IDX_W = $clog2(NBEATS);

    typedef logic [STATE_W-1:0]    state_t;
    typedef logic [BEAT_W-1:0]     beat_t;
    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(NBEATS - 1);

    // Beat k occupies state bits [BEAT_W*k + BEAT_W-1 : BEAT_W*k].
    function automatic beat_t beat_slice(input state_t state, input beat_idx_t k);
        return state[int'(k) * BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/out_beat_sel.sv
// Combinational NBEATS:1 beat multiplexer over a full Keccak state.
module out_beat_sel
    import keccak_pkg::*;
(
    input  logic [STATE_W-1:0]    state,
    input  logic [BEAT_IDX_W-1:0] idx,
    output logic [BEAT_W-1:0]     beat
);

    always_comb begin
        beat = '0;
        for (int k = 0; k < int'(NBEATS); k++) begin
            if (idx == beat_idx_t'(k)) begin
                beat = beat_slice(state, beat_idx_t'(k));
            end
        end
    end

endmodule

// File: rtl/output_interface.sv
// Streams completed Keccak states out as NBEATS indexed beats through a
// two-slot ping-pong buffer with a registered, backpressure-aware output stage.
module output_interface
    import keccak_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [STATE_W-1:0]    din,
    input  logic                  pushin,
    output logic                  stopin,
    output logic [BEAT_W-1:0]     dout,
    output logic [BEAT_IDX_W-1:0] dox,
    output logic                  pushout,
    input  logic                  stopout
);

    logic [STATE_W-1:0]    slot_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0]     dout_q, dout_d;
    logic [BEAT_IDX_W-1:0] dox_q, dox_d;
    logic                  pushout_q, pushout_d;

    logic                  accept;
    logic                  advance;
    logic                  bypass;
    logic                  pending;
    logic                  load;
    logic                  rel;
    logic [STATE_W-1:0]    src_state;
    logic [BEAT_W-1:0]     sel_beat;

    assign stopin  = (count_q == 2'd2);
    assign accept  = pushin && !stopin;
    assign advance = !pushout_q || !stopout;

    // An empty buffer forwards an arriving state straight into the output
    // stage so beat 0 appears the cycle after the accept.
    assign bypass    = (count_q == 2'd0) && accept;
    assign pending   = (count_q != 2'd0) || accept;
    assign load      = advance && pending;
    assign rel       = load && (beat_q == LAST_BEAT);
    assign src_state = bypass ? din : slot_q[rd_ptr_q];

    out_beat_sel u_beat_sel (
        .state (src_state),
        .idx   (beat_q),
        .beat  (sel_beat)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q ^ accept;
        rd_ptr_d  = rd_ptr_q ^ rel;
        count_d   = count_q;
        beat_d    = beat_q;
        dout_d    = dout_q;
        dox_d     = dox_q;
        pushout_d = pushout_q;

        unique case ({accept, rel})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (load) begin
            beat_d = rel ? '0 : beat_q + 3'd1;
        end

        if (advance) begin
            pushout_d = load;
            if (load) begin
                dout_d = sel_beat;
                dox_d  = beat_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            beat_q    <= '0;
            dout_q    <= '0;
            dox_q     <= '0;
            pushout_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            beat_q    <= beat_d;
            dout_q    <= dout_d;
            dox_q     <= dox_d;
            pushout_q <= pushout_d;
        end
    end

    // Slot storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_q[wr_ptr_q] <= din;
        end
    end

    assign dout    = dout_q;
    assign dox     = dox_q;
    assign pushout = pushout_q;

endmodule

// File: tb/tb_output_interface.sv
// Self-checking bench for output_interface: scenario tasks plus a beat-stream
// reference model built from accepted states.
module tb_output_interface;

    localparam int SW = 1600;
    localparam int BW = 200;
    localparam int NB = 8;

    typedef logic [BW+2:0] beat_rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] din;
    logic          pushin;
    logic          stopin;
    logic [BW-1:0] dout;
    logic [2:0]    dox;
    logic          pushout;
    logic          stopout;

    beat_rec_t exp_q[$];
    beat_rec_t got_q[$];
    int        got_cyc[$];
    int        acc_cyc[$];
    int        cyc = 0;
    int        n_checks = 0;
    int        n_fail = 0;

    output_interface dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .pushin  (pushin),
        .stopin  (stopin),
        .dout    (dout),
        .dox     (dox),
        .pushout (pushout),
        .stopout (stopout)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] s;
        for (int i = 0; i < SW / 32; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    // Records handshakes of the current cycle, then advances one clock.
    task automatic tick();
        if (pushin && !stopin && !reset) begin
            acc_cyc.push_back(cyc);
            for (int k = 0; k < NB; k++) exp_q.push_back({3'(k), din[k*BW +: BW]});
        end
        if (pushout && !stopout) begin
            got_q.push_back({dox, dout});
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pushin = 1'b0;
        stopout = 1'b0;
        tick();
        tick();
        n_checks++;
        if (pushout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pushout: got %b expected 0", pushout);
        end
        n_checks++;
        if (dout !== '0) begin
            n_fail++;
            $display("FAIL reset_dout: got %h expected 0", dout);
        end
        n_checks++;
        if (dox !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_dox: got %0d expected 0", dox);
        end
        n_checks++;
        if (stopin !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stopin: got %b expected 0", stopin);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({pushout, stopin} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got pushout=%b stopin=%b expected 0 0", pushout, stopin);
        end
        clear_model();
    endtask

    task automatic test_single();
        logic [SW-1:0] s;
        int a;
        clear_model();
        for (int k = 0; k < NB; k++) s[k*BW +: BW] = {25{8'(8'h10 + k)}};
        pushin = 1'b1;
        din = s;
        tick();
        pushin = 1'b0;
        din = rand_state();
        a = acc_cyc[0];
        n_checks++;
        if ({pushout, dox} !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_latency: got pushout=%b dox=%0d expected 1 0", pushout, dox);
        end
        repeat (10) tick();
        n_checks++;
        if (pushout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle_after: got pushout=%b expected 0", pushout);
        end
        n_checks++;
        if (got_q.size() != NB) begin
            n_fail++;
            $display("FAIL single_count: got %0d beats expected %0d", got_q.size(), NB);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] != a + 1 + i) begin
                n_fail++;
                $display("FAIL single_beat%0d: got %h at cycle %0d expected %h at cycle %0d",
                         i, got_q[i], got_cyc[i], exp_q[i], a + 1 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a;
        clear_model();
        pushin = 1'b1;
        din = rand_state();
        tick();
        din = rand_state();
        tick();
        a = acc_cyc[0];
        n_checks++;
        if (stopin !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_full: got stopin=%b expected 1", stopin);
        end
        din = rand_state();
        for (int i = 0; i < 20 && acc_cyc.size() < 3; i++) tick();
        pushin = 1'b0;
        n_checks++;
        if (acc_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_c_accept: got %0d accepts expected 3", acc_cyc.size());
        end else if (acc_cyc[2] != a + 8) begin
            n_fail++;
            $display("FAIL b2b_c_accept: got cycle %0d expected %0d", acc_cyc[2], a + 8);
        end
        repeat (30) tick();
        n_checks++;
        if (got_q.size() != 3 * NB) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats expected %0d", got_q.size(), 3 * NB);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] != a + 1 + i) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %h at cycle %0d expected %h at cycle %0d",
                         i, got_q[i], got_cyc[i], exp_q[i], a + 1 + i);
            end
        end
    endtask

    task automatic test_overlap();
        int a;
        clear_model();
        pushin = 1'b1;
        din = rand_state();
        tick();
        pushin = 1'b0;
        a = acc_cyc[0];
        repeat (6) tick();
        // Cycle a+7: beat 7 of A is loaded at this edge while B is accepted.
        pushin = 1'b1;
        din = rand_state();
        tick();
        n_checks++;
        if ({stopin, pushout, dox} !== 5'b0_1_111) begin
            n_fail++;
            $display("FAIL overlap_hold: got stopin=%b pushout=%b dox=%0d expected 0 1 7",
                     stopin, pushout, dox);
        end
        din = rand_state();
        tick();
        pushin = 1'b0;
        n_checks++;
        if (stopin !== 1'b1) begin
            n_fail++;
            $display("FAIL overlap_full: got stopin=%b expected 1", stopin);
        end
        repeat (30) tick();
        n_checks++;
        if (got_q.size() != 3 * NB || acc_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL overlap_count: got %0d beats/%0d accepts expected %0d/3",
                     got_q.size(), acc_cyc.size(), 3 * NB);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] != a + 1 + i) begin
                n_fail++;
                $display("FAIL overlap_beat%0d: got %h at cycle %0d expected %h at cycle %0d",
                         i, got_q[i], got_cyc[i], exp_q[i], a + 1 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] s;
        int a;
        int want;
        clear_model();
        s = rand_state();
        pushin = 1'b1;
        din = s;
        tick();
        pushin = 1'b0;
        a = acc_cyc[0];
        repeat (3) tick();
        stopout = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({pushout, dox, dout} !== {1'b1, 3'd3, s[3*BW +: BW]}) begin
                n_fail++;
                $display("FAIL bp_freeze%0d: got pushout=%b dox=%0d dout=%h expected 1 3 %h",
                         i, pushout, dox, dout, s[3*BW +: BW]);
            end
            if (i == 4) stopout = 1'b0;
            tick();
        end
        repeat (8) tick();
        n_checks++;
        if (got_q.size() != NB) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats expected %0d", got_q.size(), NB);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            want = (i < 3) ? a + 1 + i : a + 5 + i;
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] != want) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h at cycle %0d expected %h at cycle %0d",
                         i, got_q[i], got_cyc[i], exp_q[i], want);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a;
        clear_model();
        pushin = 1'b1;
        din = rand_state();
        tick();
        din = rand_state();
        tick();
        pushin = 1'b0;
        repeat (4) tick();
        n_checks++;
        if ({pushout, dox, stopin} !== 5'b1_101_1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got pushout=%b dox=%0d stopin=%b expected 1 5 1",
                     pushout, dox, stopin);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({pushout, dox, stopin} !== 5'b0_000_0 || dout !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got pushout=%b dox=%0d stopin=%b dout=%h expected 0 0 0 0",
                     pushout, dox, stopin, dout);
        end
        clear_model();
        pushin = 1'b1;
        din = rand_state();
        tick();
        pushin = 1'b0;
        a = acc_cyc[0];
        repeat (12) tick();
        n_checks++;
        if (got_q.size() != NB) begin
            n_fail++;
            $display("FAIL rstmid_count: got %0d beats expected %0d", got_q.size(), NB);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] != a + 1 + i) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: got %h at cycle %0d expected %h at cycle %0d",
                         i, got_q[i], got_cyc[i], exp_q[i], a + 1 + i);
            end
        end
    endtask

    task automatic test_random();
        logic hold;
        clear_model();
        for (int c = 0; c < 400; c++) begin
            hold = pushin && stopin;
            if (!hold) begin
                pushin = ($urandom_range(0, 1) == 1);
                din = rand_state();
            end
            stopout = ($urandom_range(0, 3) == 0);
            tick();
        end
        for (int i = 0; i < 20 && pushin && stopin; i++) tick();
        pushin = 1'b0;
        stopout = 1'b0;
        repeat (40) tick();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        pushin = 1'b0;
        stopout = 1'b0;
        din = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overlap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
